// File: rtl/ecc_pkg.sv
// Shared types and constants for the sequential GF(2^M) ECC decrypt datapath.
// Holds the FSM encoding, default widths, the point record and the latency bound.
package ecc_pkg;

  localparam int M_DEF = 4;
  localparam int K_DEF = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_BIT,
    S_DBL_INV,
    S_DBL_FIN,
    S_ADD_INV,
    S_ADD_FIN,
    S_NEXT,
    S_OUT
  } state_t;

  typedef struct packed {
    logic [M_DEF-1:0] x;
    logic [M_DEF-1:0] y;
    logic             inf;
  } point_t;

  // Worst case cycles from start acceptance to the done pulse.
  function automatic int lat_max(input int m, input int k);
    return 2 * k * (2 * m + 4) + 4;
  endfunction

endpackage

// File: rtl/gf2m_mul.sv
// Combinational GF(2^M) multiplier: MSB-first shift-and-add with
// on-the-fly reduction by the (M+1)-bit polynomial f.
module gf2m_mul #(
  parameter int M = 4
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [M:0]   f,
  output logic [M-1:0] p
);

  logic [M:0] w_t;

  // Each step doubles the partial product, folds bit M back through f,
  // then conditionally adds a.
  always_comb begin
    w_t = '0;
    for (int i = M - 1; i >= 0; i--) begin
      w_t = {w_t[M-1:0], 1'b0};
      if (w_t[M]) w_t = w_t ^ f;
      if (b[i]) w_t = w_t ^ {1'b0, a};
    end
  end

  assign p = w_t[M-1:0];

endmodule

// File: rtl/ecc_decrypt_seq.sv
// Sequential ElGamal-style decrypt: Q = d*C1 by MSB-first double-and-add on
// y^2+xy=x^3+ax^2+b over GF(2^M), then M = C2 xor Q, one shared multiplier.
module ecc_decrypt_seq
  import ecc_pkg::*;
#(
  parameter int M = M_DEF,
  parameter int K = K_DEF
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] c1x,
  input  logic [M-1:0] c1y,
  input  logic [M-1:0] c2x,
  input  logic [M-1:0] c2y,
  input  logic [K-1:0] d,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [M:0]   f,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] mx,
  output logic [M-1:0] my,
  output logic         inf_err
);

  localparam int CW = $clog2(2 * M);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(2 * M - 3);
  localparam logic [M-1:0]  ONE  = M'(1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic [K-1:0]  r_d;
  logic [M-1:0]  r_px, r_py, r_c2x, r_c2y, r_a;
  logic [M:0]    r_f;
  logic [M-1:0]  r_qx, r_qy;
  logic          r_qinf;
  logic [M-1:0]  r_t, r_acc, r_lam, r_x3, r_tmp;
  logic          r_addDbl;
  logic          r_busy, r_done, r_infErr;
  logic [M-1:0]  r_mx, r_my;

  logic [M-1:0]  w_z, w_ma, w_mb, w_prod;
  logic          w_bit;
  logic [M-1:0]  w_unused_b;

  // The curve's b term cancels out of the affine formulas.
  assign w_unused_b = b;
  assign w_bit      = r_d[r_idx];

  // Operand selection for the time-shared multiplier. Inversion alternates
  // t = t^2 (even steps) with acc = acc*t (odd steps), giving z^(2^M-2).
  always_comb begin
    w_z  = (r_state == S_ADD_INV) ? (r_qx ^ r_px) : r_qx;
    w_ma = '0;
    w_mb = '0;
    case (r_state)
      S_DBL_INV, S_ADD_INV: begin
        if (!r_cnt[0]) begin
          w_ma = (r_cnt == '0) ? w_z : r_t;
          w_mb = w_ma;
        end else begin
          w_ma = (r_cnt == CW'(1)) ? ONE : r_acc;
          w_mb = r_t;
        end
      end
      S_DBL_FIN: begin
        case (r_cnt)
          CW'(0):  begin w_ma = r_qy;        w_mb = r_acc; end
          CW'(1):  begin w_ma = r_lam;       w_mb = r_lam; end
          CW'(2):  begin w_ma = r_qx;        w_mb = r_qx;  end
          default: begin w_ma = r_lam ^ ONE; w_mb = r_x3;  end
        endcase
      end
      S_ADD_FIN: begin
        case (r_cnt)
          CW'(0):  begin w_ma = r_qy ^ r_py; w_mb = r_acc;       end
          CW'(1):  begin w_ma = r_lam;       w_mb = r_lam;       end
          default: begin w_ma = r_lam;       w_mb = r_qx ^ r_x3; end
        endcase
      end
      default: ;
    endcase
  end

  gf2m_mul #(.M(M)) u_mul (
    .a(w_ma),
    .b(w_mb),
    .f(r_f),
    .p(w_prod)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_d      <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_c2x    <= '0;
      r_c2y    <= '0;
      r_a      <= '0;
      r_f      <= '0;
      r_qx     <= '0;
      r_qy     <= '0;
      r_qinf   <= 1'b0;
      r_t      <= '0;
      r_acc    <= '0;
      r_lam    <= '0;
      r_x3     <= '0;
      r_tmp    <= '0;
      r_addDbl <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_infErr <= 1'b0;
      r_mx     <= '0;
      r_my     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_px    <= c1x;
            r_py    <= c1y;
            r_c2x   <= c2x;
            r_c2y   <= c2y;
            r_d     <= d;
            r_a     <= a;
            r_f     <= f;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_qx    <= '0;
          r_qy    <= '0;
          r_qinf  <= 1'b1;
          r_idx   <= IW'(K - 1);
          r_state <= S_BIT;
        end
        S_BIT: begin
          r_cnt    <= '0;
          r_addDbl <= 1'b0;
          if (r_qinf || r_qx == '0) begin
            r_qinf  <= 1'b1;
            r_state <= w_bit ? S_ADD_INV : S_NEXT;
          end else begin
            r_state <= S_DBL_INV;
          end
        end
        S_DBL_INV: begin
          if (!r_cnt[0]) r_t <= w_prod;
          else           r_acc <= w_prod;
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_DBL_FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DBL_FIN: begin
          r_cnt <= r_cnt + 1'b1;
          case (r_cnt)
            CW'(0): r_lam <= r_qx ^ w_prod;
            CW'(1): r_x3  <= w_prod ^ r_lam ^ r_a;
            CW'(2): r_tmp <= w_prod;
            default: begin
              r_qx     <= r_x3;
              r_qy     <= r_tmp ^ w_prod;
              r_qinf   <= 1'b0;
              r_cnt    <= '0;
              r_addDbl <= 1'b0;
              r_state  <= (w_bit && !r_addDbl) ? S_ADD_INV : S_NEXT;
            end
          endcase
        end
        S_ADD_INV: begin
          // Degenerate sums resolve before any inversion work is committed.
          if (r_cnt == '0 && r_qinf) begin
            r_qx    <= r_px;
            r_qy    <= r_py;
            r_qinf  <= 1'b0;
            r_state <= S_NEXT;
          end else if (r_cnt == '0 && r_qx == r_px && r_py == (r_qx ^ r_qy)) begin
            r_qinf  <= 1'b1;
            r_state <= S_NEXT;
          end else if (r_cnt == '0 && r_qx == r_px && r_qy == r_py) begin
            r_addDbl <= 1'b1;
            r_state  <= S_DBL_INV;
          end else begin
            if (!r_cnt[0]) r_t <= w_prod;
            else           r_acc <= w_prod;
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_state <= S_ADD_FIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_ADD_FIN: begin
          r_cnt <= r_cnt + 1'b1;
          case (r_cnt)
            CW'(0): r_lam <= w_prod;
            CW'(1): r_x3  <= w_prod ^ r_lam ^ r_qx ^ r_px ^ r_a;
            default: begin
              r_qx    <= r_x3;
              r_qy    <= w_prod ^ r_x3 ^ r_qy;
              r_qinf  <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_NEXT;
            end
          endcase
        end
        S_NEXT: begin
          if (r_idx == '0) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_infErr <= r_qinf;
            r_mx     <= r_qinf ? r_c2x : (r_c2x ^ r_qx);
            r_my     <= r_qinf ? r_c2y : (r_c2y ^ r_qy);
            r_state  <= S_OUT;
          end else begin
            r_idx   <= r_idx - 1'b1;
            r_state <= S_BIT;
          end
        end
        S_OUT: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign mx      = r_mx;
  assign my      = r_my;
  assign inf_err = r_infErr;

endmodule
